// File: rtl/yc422_pkg.sv
// Shared constants and helpers for the RGB -> YCbCr 4:2:2 converter.
// Coefficients are stored at 8 fractional bits and rescaled by the user.
package yc422_pkg;

  typedef enum logic {
    STD_601 = 1'b0,
    STD_709 = 1'b1
  } yc_std_e;

  localparam int unsigned LAT = 5;

  // Order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
  localparam int COEF_601 [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
  localparam int COEF_709 [9] = '{54, 183, 19, -29, -99, 128, 128, -116, -12};

  function automatic int coef(input yc_std_e std, input logic [3:0] idx);
    return (std == STD_709) ? COEF_709[idx] : COEF_601[idx];
  endfunction

  function automatic logic [15:0] clamp_u(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< w) - 32'sd1;
    if (v < 0) return '0;
    else if (v > max_v) return 16'(max_v);
    else return 16'(v);
  endfunction

endpackage

// File: rtl/rgb_ycc_mac.sv
// One colour-space output component: three multiplies (S1), sum plus offset (S2),
// round/shift/clamp (S3). CHROMA adds the mid-scale offset for Cb/Cr.
module rgb_ycc_mac
  import yc422_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned FRAC   = 8,
  parameter bit          CHROMA = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DW-1:0]          r_i,
  input  logic [DW-1:0]          g_i,
  input  logic [DW-1:0]          b_i,
  input  logic signed [FRAC+1:0] k_r_i,
  input  logic signed [FRAC+1:0] k_g_i,
  input  logic signed [FRAC+1:0] k_b_i,
  output logic [DW-1:0]          out_o
);

  localparam int unsigned AW = DW + FRAC + 3;
  // Rounding half-LSB, plus 2^(DW-1) scaled into the fixed-point domain for chroma
  localparam int OFF_INT = (CHROMA ? (1 << (DW - 1 + FRAC)) : 0) + (1 << (FRAC - 1));
  localparam logic signed [AW-1:0] OFFSET = AW'(OFF_INT);

  logic signed [AW-1:0] prod_d [3];
  logic signed [AW-1:0] prod_q [3];
  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] shifted;
  logic [DW-1:0]        out_q;

  always_comb begin
    prod_d[0] = signed'(AW'(r_i)) * AW'(k_r_i);
    prod_d[1] = signed'(AW'(g_i)) * AW'(k_g_i);
    prod_d[2] = signed'(AW'(b_i)) * AW'(k_b_i);
  end

  assign shifted = sum_q >>> FRAC;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q[0] <= '0;
      prod_q[1] <= '0;
      prod_q[2] <= '0;
      sum_q     <= '0;
      out_q     <= '0;
    end else begin
      prod_q[0] <= prod_d[0];
      prod_q[1] <= prod_d[1];
      prod_q[2] <= prod_d[2];
      sum_q     <= prod_q[0] + prod_q[1] + prod_q[2] + OFFSET;
      out_q     <= DW'(clamp_u(32'(shifted), DW));
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/rgb_to_yc422_param.sv
// RGB 4:4:4 -> interleaved Y/C 4:2:2, five-cycle pipeline with per-frame BT.601/709 select.
// Define YC422_CHROMA_AVG_EN to average chroma pairs instead of plain decimation.
module rgb_to_yc422_param
  import yc422_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned FRAC     = 8,
  parameter bit          CB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_std,
  input  logic [DW-1:0] i_r,
  input  logic [DW-1:0] i_g,
  input  logic [DW-1:0] i_b,
  input  logic          i_h_sync,
  input  logic          i_v_sync,
  input  logic          i_data_en,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [DW-1:0] o_y,
  output logic [DW-1:0] o_c,
  output logic          o_std
);

  localparam logic [DW-1:0] C_MID = DW'(1 << (DW - 1));

  yc_std_e        std_q;
  logic           vs_prev_q;
  logic [LAT-1:0] hs_sr_q, vs_sr_q, de_sr_q, std_sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      std_q     <= STD_601;
      vs_prev_q <= 1'b0;
      hs_sr_q   <= '0;
      vs_sr_q   <= '0;
      de_sr_q   <= '0;
      std_sr_q  <= '0;
    end else begin
      vs_prev_q <= i_v_sync;
      if (i_v_sync && !vs_prev_q) std_q <= yc_std_e'(i_std);
      hs_sr_q  <= {hs_sr_q[LAT-2:0], i_h_sync};
      vs_sr_q  <= {vs_sr_q[LAT-2:0], i_v_sync};
      de_sr_q  <= {de_sr_q[LAT-2:0], i_data_en};
      std_sr_q <= {std_sr_q[LAT-2:0], std_q};
    end
  end

  logic signed [FRAC+1:0] coef_k [9];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      coef_k[i] = (FRAC + 2)'(coef(std_q, 4'(i)) <<< (FRAC - 8));
    end
  end

  logic [DW-1:0] ycc3 [3];

  for (genvar c = 0; c < 3; c++) begin : g_mac
    rgb_ycc_mac #(
      .DW    (DW),
      .FRAC  (FRAC),
      .CHROMA(c != 0)
    ) u_mac (
      .clk_i(clk),
      .rst_i(rst),
      .r_i  (i_r),
      .g_i  (i_g),
      .b_i  (i_b),
      .k_r_i(coef_k[3*c]),
      .k_g_i(coef_k[3*c+1]),
      .k_b_i(coef_k[3*c+2]),
      .out_o(ycc3[c])
    );
  end

  logic          de3, de4;
  logic [DW-1:0] first3, second3;

  assign de3     = de_sr_q[LAT-3];
  assign de4     = de_sr_q[LAT-2];
  assign first3  = CB_FIRST ? ycc3[1] : ycc3[2];
  assign second3 = CB_FIRST ? ycc3[2] : ycc3[1];

  // S4: holds pixel n while S3 presents pixel n+1 as lookahead
  logic [DW-1:0] y4_q, first4_q, second4_q;
  logic          phase_q, phase_d;

  always_comb begin
    phase_d = 1'b0;
    if (de3 && de4) phase_d = ~phase_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y4_q      <= '0;
      first4_q  <= '0;
      second4_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      y4_q      <= ycc3[0];
      first4_q  <= first3;
      second4_q <= second3;
      phase_q   <= phase_d;
    end
  end

  logic [DW-1:0] c_sel;

`ifdef YC422_CHROMA_AVG_EN
  logic [DW-1:0] second_prev_q;
  logic [DW:0]   avg_first, avg_second;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) second_prev_q <= '0;
    else     second_prev_q <= second4_q;
  end

  always_comb begin
    avg_first  = {1'b0, first4_q} + {1'b0, first3} + 1'b1;
    avg_second = {1'b0, second_prev_q} + {1'b0, second4_q} + 1'b1;
    c_sel      = second4_q;
    // A de-low lookahead means the even pixel is unpaired and keeps its own value
    if (!phase_q) c_sel = de3 ? avg_first[DW:1] : first4_q;
    else          c_sel = avg_second[DW:1];
  end
`else
  always_comb begin
    c_sel = phase_q ? second4_q : first4_q;
  end
`endif

  logic [DW-1:0] y_q, c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      c_q <= '0;
    end else begin
      y_q <= de4 ? y4_q : '0;
      c_q <= de4 ? c_sel : C_MID;
    end
  end

  assign o_hs  = hs_sr_q[LAT-1];
  assign o_vs  = vs_sr_q[LAT-1];
  assign o_de  = de_sr_q[LAT-1];
  assign o_std = std_sr_q[LAT-1];
  assign o_y   = y_q;
  assign o_c   = c_q;

endmodule

// File: tb/tb_rgb_to_yc422_param.sv
// Directed bench for rgb_to_yc422_param: DW=8 instance plus a DW=10/FRAC=10 instance.
// Chroma expectations follow YC422_CHROMA_AVG_EN when it is defined.
module tb_rgb_to_yc422_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_std, hs, vs, de, de10;
  logic [7:0] r, g, b;
  logic [9:0] r10, g10, b10;
  logic       o_hs, o_vs, o_de, o_std;
  logic [7:0] o_y, o_c;
  logic       o_hs10, o_vs10, o_de10, o_std10;
  logic [9:0] o_y10, o_c10;

  int n_cmp = 0;
  int n_err = 0;
  int pr [16], pg [16], pb [16], ey [16], ec [16];

  rgb_to_yc422_param #(.DW(8), .FRAC(8), .CB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .i_std(i_std),
    .i_r(r), .i_g(g), .i_b(b),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_y(o_y), .o_c(o_c), .o_std(o_std)
  );

  rgb_to_yc422_param #(.DW(10), .FRAC(10), .CB_FIRST(1'b1)) dut10 (
    .clk(clk), .rst(rst), .i_std(i_std),
    .i_r(r10), .i_g(g10), .i_b(b10),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de10),
    .o_hs(o_hs10), .o_vs(o_vs10), .o_de(o_de10),
    .o_y(o_y10), .o_c(o_c10), .o_std(o_std10)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int rr, input int gg, input int bb,
                        input int yy, input int cc);
    pr[i] = rr; pg[i] = gg; pb[i] = bb; ey[i] = yy; ec[i] = cc;
  endtask

  // Drives n pixels, then idles; output for pixel k appears after the 5th edge
  task automatic run_line(input string tag, input int n);
    for (int j = 0; j < n + 6; j++) begin
      if (j < n) begin
        r = 8'(pr[j]); g = 8'(pg[j]); b = 8'(pb[j]); de = 1'b1;
      end else begin
        r = '0; g = '0; b = '0; de = 1'b0;
      end
      step();
      if (j >= 4 && j - 4 < n) begin
        check_eq($sformatf("%s de[%0d]", tag, j - 4), int'(o_de), 1);
        check_eq($sformatf("%s y[%0d]", tag, j - 4), int'(o_y), ey[j-4]);
        check_eq($sformatf("%s c[%0d]", tag, j - 4), int'(o_c), ec[j-4]);
      end else if (j == 3 || j == n + 4) begin
        check_eq($sformatf("%s idle de @%0d", tag, j), int'(o_de), 0);
        check_eq($sformatf("%s idle y @%0d", tag, j), int'(o_y), 0);
        check_eq($sformatf("%s idle c @%0d", tag, j), int'(o_c), 128);
      end
    end
  endtask

  // One-cycle hs+vs pulse; checks the 5-cycle sync delay and the latched std
  task automatic pulse_sync(input logic std);
    i_std = std;
    hs = 1'b1;
    vs = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      hs = 1'b0;
      vs = 1'b0;
      if (j == 3) begin
        check_eq("hs early", int'(o_hs), 0);
        check_eq("vs early", int'(o_vs), 0);
      end else if (j == 4) begin
        check_eq("hs at LAT", int'(o_hs), 1);
        check_eq("vs at LAT", int'(o_vs), 1);
      end else if (j == 5) begin
        check_eq("hs after", int'(o_hs), 0);
        check_eq("std latched", int'(o_std), int'(std));
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_std = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; de10 = 1'b0;
    r = '0; g = '0; b = '0; r10 = '0; g10 = '0; b10 = '0;
    step();
    step();
    check_eq("reset y", int'(o_y), 0);
    check_eq("reset c", int'(o_c), 0);
    check_eq("reset de", int'(o_de), 0);
    rst = 1'b0;
    repeat (3) step();
    check_eq("idle de", int'(o_de), 0);
    check_eq("idle c", int'(o_c), 128);
    check_eq("idle std", int'(o_std), 0);
    check_eq("idle c10", int'(o_c10), 512);

    // Reset while a line is streaming clears outputs without a clock
    r = 8'd255; g = 8'd255; b = 8'd255; de = 1'b1;
    repeat (6) step();
    check_eq("stream y", int'(o_y), 255);
    rst = 1'b1;
    #1;
    check_eq("async rst y", int'(o_y), 0);
    check_eq("async rst c", int'(o_c), 0);
    check_eq("async rst de", int'(o_de), 0);
    de = 1'b0; r = '0; g = '0; b = '0;
    step();
    rst = 1'b0;
    repeat (2) step();

    pulse_sync(1'b0);

    for (int i = 0; i < 4; i++) set_px(i, 255, 255, 255, 255, 128);
    run_line("white", 4);

    for (int i = 0; i < 4; i++) set_px(i, 255, 0, 0, 77, (i % 2 == 0) ? 85 : 255);
    run_line("red601", 4);

    // Mid-frame std change must not take effect
    i_std = 1'b1;
    run_line("red601 hold", 4);
    check_eq("std hold", int'(o_std), 0);

    pulse_sync(1'b1);
    for (int i = 0; i < 4; i++) set_px(i, 255, 0, 0, 54, (i % 2 == 0) ? 99 : 255);
    run_line("red709", 4);
    check_eq("std 709", int'(o_std), 1);

    pulse_sync(1'b0);
`ifdef YC422_CHROMA_AVG_EN
    set_px(0, 255, 0, 0, 77, 107);
    set_px(1, 0, 0, 0, 0, 192);
    set_px(2, 255, 0, 0, 77, 107);
    set_px(3, 0, 0, 0, 0, 192);
    set_px(4, 255, 0, 0, 77, 85);
    run_line("alt5", 5);
    set_px(0, 0, 0, 0, 0, 107);
    set_px(1, 255, 0, 0, 77, 192);
    run_line("next line", 2);
`else
    set_px(0, 255, 0, 0, 77, 85);
    set_px(1, 0, 0, 0, 0, 128);
    set_px(2, 255, 0, 0, 77, 85);
    set_px(3, 0, 0, 0, 0, 128);
    set_px(4, 255, 0, 0, 77, 85);
    run_line("alt5", 5);
    set_px(0, 0, 0, 0, 0, 128);
    set_px(1, 255, 0, 0, 77, 255);
    run_line("next line", 2);
`endif

    // Wide instance: mid-grey maps to mid-scale on both luma and chroma
    for (int j = 0; j < 9; j++) begin
      de10 = (j < 3);
      r10 = (j < 3) ? 10'd512 : 10'd0;
      g10 = r10;
      b10 = r10;
      step();
      if (j >= 4 && j < 7) begin
        check_eq($sformatf("dw10 de[%0d]", j - 4), int'(o_de10), 1);
        check_eq($sformatf("dw10 y[%0d]", j - 4), int'(o_y10), 512);
        check_eq($sformatf("dw10 c[%0d]", j - 4), int'(o_c10), 512);
      end else if (j == 7) begin
        check_eq("dw10 idle de", int'(o_de10), 0);
        check_eq("dw10 idle y", int'(o_y10), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
